// File: rtl/qsfp_led_register.sv
// QSFP LED state register: ControlPort target holding the 16-bit LED state and
// a small control register (blink enable, lamp test), driving the LED pins.
//
// Ports:
//   ctrlport_clk / ctrlport_rst_n      clock and async active-low reset
//   s_ctrlport_req_*                   single-cycle ControlPort request
//   s_ctrlport_resp_*                  registered response, 1 cycle latency
//   qsfp_led[15:0]                     LED pins, same bit layout as the register:
//                                      [15:12] qsfp1 active, [11:8] qsfp1 link,
//                                      [7:4] qsfp0 active, [3:0] qsfp0 link
module qsfp_led_register #(
    parameter int unsigned BASE_ADDRESS      = 0,
    parameter int unsigned BLINK_HALF_PERIOD = 5000000,
    parameter bit          LED_ACTIVE_LOW    = 1'b1
) (
    input  logic        ctrlport_clk,
    input  logic        ctrlport_rst_n,
    input  logic        s_ctrlport_req_wr,
    input  logic        s_ctrlport_req_rd,
    input  logic [19:0] s_ctrlport_req_addr,
    input  logic [31:0] s_ctrlport_req_data,
    input  logic [3:0]  s_ctrlport_req_byte_en,
    output logic        s_ctrlport_resp_ack,
    output logic [1:0]  s_ctrlport_resp_status,
    output logic [31:0] s_ctrlport_resp_data,
    output logic [15:0] qsfp_led
);

    localparam int unsigned CNT_W  = 24;
    localparam int unsigned LED_W  = 16;
    localparam int unsigned WORD_W = 18;

    localparam logic [WORD_W-1:0] LED_WORD  = WORD_W'(BASE_ADDRESS >> 2);
    localparam logic [WORD_W-1:0] CTRL_WORD = WORD_W'((BASE_ADDRESS + 4) >> 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLINK_HALF_PERIOD - 1);
    // XOR mask that turns a "lit" vector into pin levels
    localparam logic [LED_W-1:0]  POL_MASK  = {LED_W{LED_ACTIVE_LOW}};

    localparam logic [1:0] STATUS_OKAY   = 2'b00;
    localparam logic [1:0] STATUS_CMDERR = 2'b01;

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    logic [LED_W-1:0] led_state;
    logic             blink_en;
    logic             lamp_test;
    logic [CNT_W-1:0] blink_cnt;
    logic             phase;

    logic             hit_led_c;
    logic             hit_ctrl_c;
    logic             access_c;
    logic [LED_W-1:0] led_lit_c;
    logic             unused_bits_c;

    // Async assert, synchronised release of the internal reset
    always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
        if (!ctrlport_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // Word-aligned decode; byte offset bits are don't-care
    assign hit_led_c  = (s_ctrlport_req_addr[19:2] == LED_WORD);
    assign hit_ctrl_c = (s_ctrlport_req_addr[19:2] == CTRL_WORD);
    assign access_c   = (hit_led_c || hit_ctrl_c) &&
                        (s_ctrlport_req_wr || s_ctrlport_req_rd);

    assign unused_bits_c = ^{s_ctrlport_req_addr[1:0], s_ctrlport_req_data[31:16],
                             s_ctrlport_req_byte_en[3:2]};

    // Register file and response
    always_ff @(posedge ctrlport_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            led_state              <= '0;
            blink_en               <= 1'b1;
            lamp_test              <= 1'b0;
            s_ctrlport_resp_ack    <= 1'b0;
            s_ctrlport_resp_status <= STATUS_OKAY;
            s_ctrlport_resp_data   <= '0;
        end else begin
            s_ctrlport_resp_ack    <= 1'b0;
            s_ctrlport_resp_status <= STATUS_OKAY;
            s_ctrlport_resp_data   <= '0;
            if (access_c) begin
                s_ctrlport_resp_ack <= 1'b1;
                if (s_ctrlport_req_wr && s_ctrlport_req_rd) begin
                    // Ambiguous request: reject without touching state
                    s_ctrlport_resp_status <= STATUS_CMDERR;
                end else if (s_ctrlport_req_wr) begin
                    if (hit_led_c) begin
                        if (s_ctrlport_req_byte_en[0]) begin
                            led_state[7:0] <= s_ctrlport_req_data[7:0];
                        end
                        if (s_ctrlport_req_byte_en[1]) begin
                            led_state[15:8] <= s_ctrlport_req_data[15:8];
                        end
                    end else if (s_ctrlport_req_byte_en[0]) begin
                        blink_en  <= s_ctrlport_req_data[0];
                        lamp_test <= s_ctrlport_req_data[1];
                    end
                end else if (hit_led_c) begin
                    s_ctrlport_resp_data <= {16'b0, led_state};
                end else begin
                    s_ctrlport_resp_data <= {30'b0, lamp_test, blink_en};
                end
            end
        end
    end

    // Blink timer; disabling holds the active LEDs solid on
    always_ff @(posedge ctrlport_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
        end
    end

    // Link nibbles pass through, active nibbles gated by blink phase
    always_comb begin
        led_lit_c = {led_state[15:12] & {4{phase}}, led_state[11:8],
                     led_state[7:4] & {4{phase}}, led_state[3:0]};
        if (lamp_test) begin
            led_lit_c = '1;
        end
    end

    always_ff @(posedge ctrlport_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            qsfp_led <= POL_MASK;
        end else begin
            qsfp_led <= led_lit_c ^ POL_MASK;
        end
    end

endmodule

// File: doc/qsfp_led_register.md
Name: qsfp_led_register

Overview:
- CPLD-side ControlPort target; consumer of the LED write requests the FPGA issues whenever QSFP link/active LED state changes.
- Holds the 16-bit QSFP LED state register plus a small control register, acknowledges every access inside its window, and drives the 16 physical LED pins.
- Blinks active LEDs, holds link LEDs solid, and supports a lamp-test override.

Parameters:
- BASE_ADDRESS, 0, byte address of LED state register; control register at BASE_ADDRESS+4.
- BLINK_HALF_PERIOD, 5000000, ctrlport_clk cycles per blink half-period; legal range 2 to 2^24-1.
- LED_ACTIVE_LOW, 1, 1 = LED pins driven low when lit.

Ports:
- ctrlport_clk  in  1  ControlPort clock, also the LED timing clock.
- ctrlport_rst_n  in  1  reset, asynchronous assert, active-low.
- s_ctrlport_req_wr  in  1  single-cycle write strobe.
- s_ctrlport_req_rd  in  1  single-cycle read strobe.
- s_ctrlport_req_addr  in  20  byte address.
- s_ctrlport_req_data  in  32  write data.
- s_ctrlport_req_byte_en  in  4  write byte enables.
- s_ctrlport_resp_ack  out  1  single-cycle response strobe.
- s_ctrlport_resp_status  out  2  00 OKAY, 01 CMDERR.
- s_ctrlport_resp_data  out  32  read data, 0 on writes.
- qsfp_led  out  16  LED pins, same bit layout as register: [15:12] qsfp1 active, [11:8] qsfp1 link, [7:4] qsfp0 active, [3:0] qsfp0 link.

Behaviour:
- Reset (ctrlport_rst_n low, async):
  - led_state = 0; ctrl = 0x1 (blink_en = 1, lamp_test = 0); blink counter = 0; phase = 0.
  - resp_ack = 0; resp_status = 0; resp_data = 0.
  - qsfp_led = all unlit (0xFFFF if LED_ACTIVE_LOW, else 0x0000).
- Address decode: compare addr[19:2] only; addr[1:0] ignored.
  - Hit = BASE_ADDRESS or BASE_ADDRESS+4.
  - Any other address: no ack, no state change, so a downstream combiner can time out.
- Response latency: exactly 1 cycle. A request at cycle N gives resp_ack high at N+1 only; back-to-back requests on consecutive cycles each get an ack.
- LED state register write:
  - byte_en[0] updates bits [7:0]; byte_en[1] updates bits [15:8]; byte_en[3:2] ignored.
  - Write with byte_en = 0: acked OKAY, no change.
- Control register write: byte_en[0] updates bit0 blink_en and bit1 lamp_test; other bits ignored.
- Reads: return {16'b0, led_state} or {30'b0, lamp_test, blink_en}; status OKAY.
- wr and rd both high on a hit: no register update; ack with status CMDERR and resp_data 0.
- Blink timer:
  - Counter runs 0..BLINK_HALF_PERIOD-1 while blink_en = 1.
  - On wrap, phase toggles.
  - blink_en = 0 forces counter = 0 and phase = 1 (active LEDs solid).
- LED output is registered, 1 cycle after state change. Lit value per bit:
  - Link bits: led_state bit.
  - Active bits: led_state bit AND phase.
  - lamp_test = 1 overrides: all 16 lit.
  - Polarity applied last per LED_ACTIVE_LOW.
- Write to the LED state register takes effect on qsfp_led 2 cycles after the request (register update, then output register).
- Reset mid-operation: a pending ack is dropped and all state returns to reset values immediately.
- Release of reset is synchronised internally with a 2-flop deassertion synchronizer; the first request is honoured on the 3rd cycle after release.

Test Plan:
- Reset, LED_ACTIVE_LOW = 1 -> qsfp_led = 0xFFFF, resp_ack = 0; read BASE+4 returns 0x00000001.
- Write BASE, data 0x0000_0F0A, byte_en 4'b0011 -> ack next cycle, status 00; qsfp_led[3:0] = 4'b0101 after 2 cycles; read BASE returns 0x00000F0A.
- BLINK_HALF_PERIOD = 4, led_state = 0x00F0 -> qsfp_led[7:4] toggles between 0x0 and 0xF every 4 cycles; link bits constant.
- Write BASE, byte_en 4'b0010, data 0x0000_A5FF -> led_state[15:8] = 0xA5, [7:0] unchanged; write to BASE+0x10 -> no ack within 16 cycles.
- Write BASE+4, data 0x2 (lamp test on) -> qsfp_led = 0x0000 after 2 cycles; simultaneous wr+rd to BASE -> ack with status 01, led_state unchanged.
- Assert ctrlport_rst_n during a write's ack cycle -> resp_ack drops asynchronously, qsfp_led = 0xFFFF, led_state reads 0 after release.
